// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
// Optional subtract mode is enabled with SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit operation still needs a one-bit counter.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_digit_adder_fa_digit.sv
// DIGIT-bit ripple slice built from chained full-adder cells.
// Purely combinational; shared by every digit of an operation.
module fa_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] A,
    input  logic [DIGIT-1:0] B,
    input  logic             CI,
    output logic [DIGIT-1:0] S,
    output logic             CO
);

    logic [DIGIT:0] c;

    assign c[0] = CI;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i]);
    end

    assign CO = c[DIGIT];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder: DIGIT bits per clock through one ripple slice.
// Define SERIAL_ADDER_SUB_EN to add the SUB port (A - B mode).
module serial_digit_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             BUSY
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_w(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             co_q, co_d;

    logic [DIGIT-1:0] dsum;
    logic             dco;
    logic [WIDTH-1:0] full;

    fa_digit #(
        .DIGIT (DIGIT)
    ) u_fa (
        .A  (a_q[DIGIT-1:0]),
        .B  (b_q[DIGIT-1:0]),
        .CI (cy_q),
        .S  (dsum),
        .CO (dco)
    );

    // Finished digits enter at the top and drift down, so after the
    // last digit the running sum plus the new digit is the full result.
    if (NDIG > 1) begin : g_acc
        logic [WIDTH-DIGIT-1:0] acc_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                acc_q <= '0;
            end else if (state_q == RUN) begin
                acc_q <= full[WIDTH-1:DIGIT];
            end
        end

        assign full = {dsum, acc_q};
    end else begin : g_noacc
        assign full = dsum;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        co_d    = co_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    a_d     = A;
                    b_d     = B;
                    cy_d    = CIN;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_ADDER_SUB_EN
                    if (SUB) begin
                        b_d  = ~B;
                        cy_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cy_d  = dco;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = full;
                    co_d    = dco;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            co_q    <= co_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q != IDLE);
    assign S         = s_q;
    assign COUT      = co_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder (DIGIT=4 main, DIGIT=1/16 sweep).
// SUB-mode vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_digit_adder;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] a, b;
    logic cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub;
`endif

    logic iv0, ir0, ov0, or0, c0, bz0;
    logic iv1, ir1, ov1, or1, c1, bz1;
    logic iv16, ir16, ov16, or16, c16, bz16;
    logic [15:0] s0, s1, s16;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(iv0), .IN_READY(ir0),
        .A(a), .B(b), .CIN(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub),
`endif
        .OUT_VALID(ov0), .OUT_READY(or0), .S(s0), .COUT(c0), .BUSY(bz0)
    );

    serial_digit_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .CLK(clk), .RST(rst), .IN_VALID(iv1), .IN_READY(ir1),
        .A(a), .B(b), .CIN(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub),
`endif
        .OUT_VALID(ov1), .OUT_READY(or1), .S(s1), .COUT(c1), .BUSY(bz1)
    );

    serial_digit_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .CLK(clk), .RST(rst), .IN_VALID(iv16), .IN_READY(ir16),
        .A(a), .B(b), .CIN(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub),
`endif
        .OUT_VALID(ov16), .OUT_READY(or16), .S(s16), .COUT(c16), .BUSY(bz16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op_main(input logic [15:0] ta, input logic [15:0] tb_,
                           input logic tc, input logic [15:0] es,
                           input logic ec, input string tag);
        int n;
        chk({tag, "_ready_idle"}, ir0, 1);
        a   = ta;
        b   = tb_;
        cin = tc;
        iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        n = 1;
        while (ov0 !== 1'b1 && n < 30) begin
            chk({tag, "_ready_run"}, ir0, 0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 5);
        chk({tag, "_ready_done"}, ir0, 0);
        chk({tag, "_busy"}, bz0, 1);
        chk({tag, "_sum"}, s0, es);
        chk({tag, "_cout"}, c0, ec);
        or0 = 1'b1;
        tick();
        or0 = 1'b0;
        chk({tag, "_ready_after"}, ir0, 1);
        chk({tag, "_valid_after"}, ov0, 0);
        chk({tag, "_sum_hold"}, s0, es);
    endtask

    initial begin
        int n, l1, l16;
        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        iv0 = 0; or0 = 0; iv1 = 0; or1 = 0; iv16 = 0; or16 = 0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ready", ir0, 1);
        chk("rst_valid", ov0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_sum", s0, 0);
        chk("rst_cout", c0, 0);

        op_main(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "add_basic");
        op_main(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "carry_chain");
        op_main(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "all_ones");

        // Backpressure with junk handshakes and operand changes in RUN
        a = 16'h1234; b = 16'h4321; cin = 1'b0;
        iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        tick();
        iv0 = 1'b1; a = 16'hAAAA; b = 16'hBBBB; cin = 1'b1;
        tick();
        iv0 = 1'b0;
        tick();
        tick();
        chk("bp_valid_first", ov0, 1);
        chk("bp_sum_first", s0, 16'h5555);
        iv0 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid_hold", ov0, 1);
            chk("bp_sum_hold", s0, 16'h5555);
            chk("bp_cout_hold", c0, 0);
            chk("bp_ready_low", ir0, 0);
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        tick();
        or0 = 1'b0;
        chk("bp_ready_release", ir0, 1);
        chk("bp_valid_release", ov0, 0);
        chk("bp_busy_release", bz0, 0);
        tick();
        chk("bp_no_capture", ir0, 1);
        chk("bp_sum_kept", s0, 16'h5555);

        // Reset during the second RUN cycle discards the operation
        a = 16'h1111; b = 16'h2222; cin = 1'b0;
        iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", ir0, 1);
        chk("midrst_valid", ov0, 0);
        chk("midrst_busy", bz0, 0);
        chk("midrst_sum", s0, 0);
        chk("midrst_cout", c0, 0);
        op_main(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, "after_rst");

        // Bit-serial and single-digit instances side by side
        a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1;
        iv1 = 1'b1; iv16 = 1'b1;
        tick();
        iv1 = 1'b0; iv16 = 1'b0;
        n = 1; l1 = 0; l16 = 0;
        while ((l1 == 0 || l16 == 0) && n < 40) begin
            if (ov1 === 1'b1 && l1 == 0) l1 = n;
            if (ov16 === 1'b1 && l16 == 0) l16 = n;
            tick();
            n++;
        end
        chk("d1_latency", l1, 17);
        chk("d16_latency", l16, 2);
        chk("d1_sum", s1, 16'h0000);
        chk("d1_cout", c1, 1);
        chk("d16_sum", s16, 16'h0000);
        chk("d16_cout", c16, 1);
        or1 = 1'b1; or16 = 1'b1;
        tick();
        or1 = 1'b0; or16 = 1'b0;
        chk("d1_ready_after", ir1, 1);
        chk("d16_ready_after", ir16, 1);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        op_main(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
        op_main(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, "sub_noborrow");
        sub = 1'b0;
        op_main(16'h0007, 16'h0005, 1'b1, 16'h000D, 1'b0, "sub_off_add");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
